program_memory: RTL and testbench

//  Responder end of the accumulator core's memory interface: serves combinational program

---
 rtl/program_memory.sv | 119 +++++++++++
 tb/tb_program_memory.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// program_memory: responder side of the accumulator core's memory interface.
// Serves combinational fetch/operand reads, absorbs core write-backs while the
// core runs, and lets a host stream a program image in or a memory image out
// over valid/ready byte links while the core is held in reset.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | host owns memory, core held in reset, waiting for a command
//   LOAD  | accepting load words into mem[ptr], ptr advancing
//   RUN   | core released, core write-backs land in mem[op_addr]
//   DUMP  | presenting mem[ptr] to the host, ptr advancing on ready
module program_memory #(
  parameter int word_width = 8,
  localparam int AW = $clog2(word_width)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         pc_addr,
  output logic [word_width-1:0] pc_data,
  input  logic [AW-1:0]         op_addr,
  output logic [word_width-1:0] op_data,
  input  logic                  write,
  input  logic [word_width-1:0] wr_data,
  input  logic                  cmd_load,
  input  logic                  cmd_dump,
  input  logic                  cmd_run,
  input  logic                  cmd_halt,
  input  logic [word_width-1:0] ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic [word_width-1:0] dump_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  core_reset,
  output logic [1:0]            state
);

  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;
  localparam logic [1:0] DUMP = 2'b11;

  logic [word_width-1:0] mem [DEPTH];
  logic [AW-1:0]         ptr;
  logic                  ptr_last;
  logic                  ld_fire;
  logic                  dump_fire;
  logic                  core_wr;

  // ptr covers the full address space, so the last word is simply all-ones
  assign ptr_last   = (ptr == AW'(DEPTH - 1));
  assign ld_ready   = (state == LOAD);
  assign dump_valid = (state == DUMP);
  assign ld_fire    = ld_ready & ld_valid;
  assign dump_fire  = dump_valid & dump_ready;
  assign core_wr    = (state == RUN) & write;

  assign pc_data   = mem[pc_addr];
  assign op_data   = mem[op_addr];
  assign dump_data = mem[ptr];

  // Host sequencer: command decode in IDLE, pointer walk in LOAD/DUMP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_load) begin
            ptr   <= '0;
            state <= LOAD;
          end else if (cmd_dump) begin
            ptr   <= '0;
            state <= DUMP;
          end else if (cmd_run) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (ld_fire) begin
            ptr <= ptr + AW'(1);
            if (ptr_last) state <= IDLE;
          end
        end
        RUN: begin
          if (cmd_halt) state <= IDLE;
        end
        DUMP: begin
          if (dump_fire) begin
            ptr <= ptr + AW'(1);
            if (ptr_last) state <= IDLE;
          end
        end
      endcase
    end
  end

  // Core reset follows the current state one cycle late, so the core is
  // released only after the sequencer has settled in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) core_reset <= 1'b1;
    else        core_reset <= (state != RUN);
  end

  // Storage: cleared on reset, written by the load stream or the running core
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ld_fire) begin
      mem[ptr] <= ld_data;
    end else if (core_wr) begin
      mem[op_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: reset, load, run with write-back, dump
// with backpressure, command priority, ignored writes and reset mid-load.
module tb_program_memory;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] pc_addr = '0;
  logic [7:0] pc_data;
  logic [2:0] op_addr = '0;
  logic [7:0] op_data;
  logic       write = 1'b0;
  logic [7:0] wr_data = '0;
  logic       cmd_load = 1'b0;
  logic       cmd_dump = 1'b0;
  logic       cmd_run = 1'b0;
  logic       cmd_halt = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [7:0] dump_data;
  logic       dump_valid;
  logic       dump_ready = 1'b0;
  logic       core_reset;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mem [8];
  logic [7:0] q [$];

  program_memory dut (
    .clk(clk), .reset(reset),
    .pc_addr(pc_addr), .pc_data(pc_data),
    .op_addr(op_addr), .op_data(op_data),
    .write(write), .wr_data(wr_data),
    .cmd_load(cmd_load), .cmd_dump(cmd_dump), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .core_reset(core_reset), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_mem(input string tag);
    for (int a = 0; a < 8; a++) begin
      pc_addr = 3'(a);
      op_addr = 3'(7 - a);
      #1;
      check({tag, "_pc"}, pc_data, exp_mem[a]);
      check({tag, "_op"}, op_data, exp_mem[7 - a]);
    end
  endtask

  // Load 8 words with random idle gaps; pushes each word to the scoreboard
  task automatic load_image(input logic [7:0] base);
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    check("load_enter_state", state, 2'b01);
    check("load_ready", ld_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        ld_valid = 1'b0;
        tick();
        check("load_gap_state", state, 2'b01);
      end
      ld_valid = 1'b1;
      ld_data  = base + 8'(i);
      exp_mem[i] = ld_data;
      q.push_back(ld_data);
      tick();
      check("load_core_reset", core_reset, 1'b1);
    end
    ld_valid = 1'b0;
    check("load_exit_state", state, 2'b00);
    check("load_exit_ready", ld_ready, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] e;

    for (int i = 0; i < 8; i++) exp_mem[i] = '0;

    // 1: reset state
    tick();
    tick();
    check("rst_state", state, 2'b00);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_dump_valid", dump_valid, 1'b0);
    check_all_mem("rst_mem");
    reset = 1'b1;
    tick();

    // 2: load 01..08 with gaps, then verify image through the scoreboard
    load_image(8'h01);
    for (int a = 0; a < 8; a++) begin
      pc_addr = 3'(a);
      #1;
      e = q.pop_front();
      check("load_word", pc_data, e);
    end

    // 3: run, core write-back, halt with a simultaneous write
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    check("run_state", state, 2'b10);
    check("run_core_reset_lag", core_reset, 1'b1);
    tick();
    check("run_core_reset", core_reset, 1'b0);
    op_addr = 3'd3;
    write   = 1'b1;
    wr_data = 8'hA5;
    #1;
    check("run_pre_write", op_data, 8'h04);
    tick();
    write = 1'b0;
    exp_mem[3] = 8'hA5;
    check("run_write", op_data, 8'hA5);
    op_addr  = 3'd5;
    write    = 1'b1;
    wr_data  = 8'h5A;
    cmd_halt = 1'b1;
    tick();
    write    = 1'b0;
    cmd_halt = 1'b0;
    exp_mem[5] = 8'h5A;
    check("halt_state", state, 2'b00);
    check("halt_write", op_data, 8'h5A);
    check("halt_core_reset_lag", core_reset, 1'b0);
    tick();
    check("halt_core_reset", core_reset, 1'b1);

    // 4: dump with initial stall then toggling ready
    for (int i = 0; i < 8; i++) q.push_back(exp_mem[i]);
    cmd_dump = 1'b1;
    tick();
    cmd_dump = 1'b0;
    check("dump_state", state, 2'b11);
    for (int c = 0; c < 5; c++) begin
      check("dump_stall_valid", dump_valid, 1'b1);
      check("dump_stall_data", dump_data, q[0]);
      tick();
    end
    n = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      dump_ready = c[0];
      #1;
      if (dump_valid && dump_ready) begin
        e = q.pop_front();
        check("dump_word", dump_data, e);
        n++;
      end else if (dump_valid) begin
        check("dump_hold", dump_data, q[0]);
      end
      tick();
    end
    dump_ready = 1'b0;
    check("dump_count", n, 8);
    check("dump_exit_state", state, 2'b00);
    check("dump_exit_valid", dump_valid, 1'b0);

    // 5: command priority, writes outside RUN ignored, halt ignored in IDLE
    cmd_load = 1'b1;
    cmd_dump = 1'b1;
    cmd_run  = 1'b1;
    tick();
    cmd_load = 1'b0;
    cmd_dump = 1'b0;
    cmd_run  = 1'b0;
    check("prio_state", state, 2'b01);
    op_addr = 3'd2;
    write   = 1'b1;
    wr_data = 8'hFF;
    tick();
    check("load_write_ignored", op_data, exp_mem[2]);
    check("load_write_state", state, 2'b01);
    for (int i = 0; i < 8; i++) begin
      op_addr  = 3'(i);
      ld_valid = 1'b1;
      ld_data  = 8'h10 + 8'(i);
      exp_mem[i] = ld_data;
      tick();
    end
    ld_valid = 1'b0;
    check("prio_exit_state", state, 2'b00);
    op_addr  = 3'd2;
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    write    = 1'b0;
    check("idle_halt_state", state, 2'b00);
    check("idle_write_ignored", op_data, 8'h12);
    check_all_mem("img2");

    // 6: reset in the middle of a load clears everything
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'hC0 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    check("mid_load_state", state, 2'b01);
    reset = 1'b0;
    #2;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    check("abort_state", state, 2'b00);
    check("abort_core_reset", core_reset, 1'b1);
    check("abort_ld_ready", ld_ready, 1'b0);
    check_all_mem("abort_mem");
    tick();
    reset = 1'b1;
    tick();
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 8'h77;
    tick();
    ld_valid = 1'b0;
    pc_addr = 3'd0;
    op_addr = 3'd1;
    #1;
    check("restart_addr0", pc_data, 8'h77);
    check("restart_addr1", op_data, 8'h00);
    check("restart_state", state, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
